// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the 3x3 median filter: streams a WIDTH x HEIGHT frame from source memory into
// the filter, writes the filter output to destination memory and guards DRAIN with a watchdog.
// Optional build macro MFC_BUBBLE_EN inserts a read gap every BUBBLE_PERIOD-th FEED cycle.
`timescale 1ns/1ps
module median_frame_ctrl #(
  parameter int WIDTH         = 430,
  parameter int HEIGHT        = 554,
  parameter int ADDR_W        = 18,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int BUBBLE_PERIOD = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_extra,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_rdata,
  output logic              flt_in_valid,
  output logic [7:0]        flt_pixel_in,
  input  logic              flt_out_valid,
  input  logic [7:0]        flt_pixel_out,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_wdata,
  output logic [ADDR_W-1:0] out_count
);

  localparam int unsigned N     = WIDTH * HEIGHT;
  // One spare bit so a full frame count is representable even when N == 2**ADDR_W.
  localparam int          CNT_W = ADDR_W + 1;
  localparam int          WD_W  = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, FIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  out_cnt;
  logic [WD_W-1:0]   wdog;
  logic              gap_next;
  logic              capture;

`ifdef MFC_BUBBLE_EN
  localparam int               GAP_W    = (BUBBLE_PERIOD > 1) ? $clog2(BUBBLE_PERIOD) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BUBBLE_PERIOD - 1);

  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_next;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    gap_cnt_next = (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
    gap_next     = (gap_cnt_next == GAP_LAST);
  end

  // Cycle counter of the feed phase; phase 0 is the first read after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state == IDLE && start) begin
      gap_cnt <= '0;
    end else if (state == FEED) begin
      gap_cnt <= gap_cnt_next;
    end
  end
`else
  assign gap_next = 1'b0;
`endif

  assign capture   = flt_out_valid && (state == FEED || state == DRAIN);
  assign out_count = out_cnt[ADDR_W-1:0];

  // The source memory's own output register supplies the one-cycle delay, so the pixel is
  // paired with the registered read strobe here and forced to zero outside valid beats.
  assign flt_pixel_in = flt_in_valid ? src_rdata : 8'h00;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      err_extra    <= 1'b0;
      src_rd_en    <= 1'b0;
      src_addr     <= '0;
      rd_ptr       <= '0;
      flt_in_valid <= 1'b0;
      dst_we       <= 1'b0;
      dst_addr     <= '0;
      dst_wdata    <= 8'h00;
      out_cnt      <= '0;
      wdog         <= '0;
    end else begin
      done         <= 1'b0;
      dst_we       <= 1'b0;
      flt_in_valid <= src_rd_en;

      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= FEED;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            err_extra   <= 1'b0;
            out_cnt     <= '0;
            wdog        <= '0;
            src_rd_en   <= 1'b1;
            src_addr    <= '0;
            rd_ptr      <= CNT_W'(1);
          end
        end

        FEED: begin
          if (src_rd_en && src_addr == LAST_ADDR) begin
            state     <= DRAIN;
            src_rd_en <= 1'b0;
          end else if (gap_next) begin
            src_rd_en <= 1'b0;
          end else begin
            src_rd_en <= 1'b1;
            src_addr  <= rd_ptr[ADDR_W-1:0];
            rd_ptr    <= rd_ptr + 1'b1;
          end
        end

        DRAIN: begin
          // Completion is tested first so it wins over a same-cycle watchdog expiry.
          if (out_cnt == N_CNT) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!flt_out_valid && wdog == WD_LAST) begin
            state       <= FIN;
            busy        <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end else if (flt_out_valid) begin
            wdog <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      if (capture) begin
        if (out_cnt != N_CNT) begin
          dst_we    <= 1'b1;
          dst_addr  <= out_cnt[ADDR_W-1:0];
          dst_wdata <= flt_pixel_out;
          out_cnt   <= out_cnt + 1'b1;
        end else begin
          err_extra <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Self-checking bench for median_frame_ctrl on a 4x3 frame: memory and echo-filter models,
// a negedge monitor, and a frame-level reference derived from the frame rules.
`timescale 1ns/1ps
module tb_median_frame_ctrl;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int N      = WIDTH * HEIGHT;
  localparam int ADDR_W = 4;
  localparam int TMO    = 16;
  localparam int BP     = 3;
  localparam int LAT    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, err_timeout, err_extra;
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_rdata = 8'h00;
  logic              flt_in_valid;
  logic [7:0]        flt_pixel_in;
  logic              flt_out_valid = 1'b0;
  logic [7:0]        flt_pixel_out = 8'h00;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        dst_wdata;
  logic [ADDR_W-1:0] out_count;

  always #5 clk = ~clk;

  median_frame_ctrl #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W),
    .DRAIN_TIMEOUT(TMO), .BUBBLE_PERIOD(BP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_extra(err_extra),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .flt_in_valid(flt_in_valid), .flt_pixel_in(flt_pixel_in),
    .flt_out_valid(flt_out_valid), .flt_pixel_out(flt_pixel_out),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .out_count(out_count)
  );

  wire [34:0] all_outs = {busy, done, err_timeout, err_extra, src_rd_en, src_addr, flt_in_valid,
                          flt_pixel_in, dst_we, dst_addr, dst_wdata, out_count};

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source frame buffer: synchronous read, data one cycle after the strobe.
  logic [7:0] src_mem [16];
  always @(posedge clk) if (src_rd_en) src_rdata <= src_mem[src_addr];

  // Filter model: echoes each input beat LAT cycles later, with optional output bubbles,
  // an output limit (stall) and one surplus output after a full frame.
  typedef struct {
    logic [7:0] px;
    int         due;
  } beat_t;

  bit bubbles = 1'b0;
  bit extra = 1'b0;
  int emit_limit = N;
  int model_id = 0;
  int mon_id = 0;

  beat_t pend[$];
  int    model_seen = 0;
  int    emitted = 0;
  int    hold = 0;
  bit    extra_done = 1'b0;

  always @(negedge clk) begin
    beat_t b;
    if (model_id != model_seen) begin
      model_seen = model_id;
      pend.delete();
      emitted    = 0;
      hold       = 0;
      extra_done = 1'b0;
    end
    if (flt_in_valid) begin
      b.px  = flt_pixel_in;
      b.due = cyc + LAT;
      pend.push_back(b);
    end
    flt_out_valid = 1'b0;
    if (hold > 0) begin
      hold--;
    end else if (pend.size() > 0 && pend[0].due <= cyc && emitted < emit_limit) begin
      b = pend.pop_front();
      flt_out_valid = 1'b1;
      flt_pixel_out = b.px;
      emitted++;
      if (bubbles && emitted % 4 == 0) hold = 3;
    end else if (extra && !extra_done && emitted == N && pend.size() == 0) begin
      flt_out_valid = 1'b1;
      flt_pixel_out = 8'hE5;
      extra_done    = 1'b1;
    end
  end

  // Monitor: records every DUT transaction with its cycle number.
  int         mon_seen = 0;
  int         rd_addr_q[$], rd_cyc_q[$], in_cyc_q[$], wr_addr_q[$], wr_cyc_q[$];
  logic [7:0] in_px_q[$], wr_data_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (mon_id != mon_seen) begin
      mon_seen = mon_id;
      rd_addr_q.delete(); rd_cyc_q.delete(); in_cyc_q.delete(); in_px_q.delete();
      wr_addr_q.delete(); wr_cyc_q.delete(); wr_data_q.delete();
      done_cnt = 0;
      done_cyc = 0;
      busy_at_done = 1'b0;
    end
    if (rst_n) begin
      if (src_rd_en) begin
        rd_addr_q.push_back(int'(src_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (flt_in_valid) begin
        in_cyc_q.push_back(cyc);
        in_px_q.push_back(flt_pixel_in);
      end
      if (dst_we) begin
        wr_addr_q.push_back(int'(dst_addr));
        wr_data_q.push_back(dst_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input bit bub, input int limit, input bit xtra, input int restart_at,
                           output int s);
    bubbles    = bub;
    emit_limit = limit;
    extra      = xtra;
    for (int i = 0; i < N; i++) src_mem[i] = 8'($urandom);
    model_id++;
    mon_id++;
    s = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("state_cleared_after_start", 64'({err_timeout, err_extra, out_count}), 64'(0));
    for (int i = 1; i < 400 && done_cnt == 0; i++) begin
      start = (restart_at != 0 && i == restart_at);
      tick(1);
    end
    start = 1'b0;
    check("done_within_budget", 64'(done_cnt != 0), 64'(1));
    tick(6);
  endtask

  // Frame-level reference: N reads at addresses 0..N-1 from the cycle after start (skipping
  // every BP-th feed cycle in the bubble build), each pixel reaching the filter one cycle later,
  // and the first n_wr filter outputs (the echoed frame) written at addresses 0..n_wr-1.
  task automatic verify(input string tag, input int s, input int n_wr,
                        input bit exp_tmo, input bit exp_extra);
    int exp_c;
    exp_c = s + 1;
    check({tag, "_rd_count"}, 64'(rd_addr_q.size()), 64'(N));
    check({tag, "_in_count"}, 64'(in_cyc_q.size()), 64'(N));
    for (int i = 0; i < N; i++) begin
`ifdef MFC_BUBBLE_EN
      while ((exp_c - (s + 1)) % BP == BP - 1) exp_c++;
`endif
      if (i < rd_addr_q.size()) begin
        check({tag, "_rd_addr"}, 64'(rd_addr_q[i]), 64'(i));
        check({tag, "_rd_cycle"}, 64'(rd_cyc_q[i]), 64'(exp_c));
      end
      if (i < in_cyc_q.size()) begin
        check({tag, "_in_cycle"}, 64'(in_cyc_q[i]), 64'(exp_c + 1));
        check({tag, "_in_pixel"}, 64'(in_px_q[i]), 64'(src_mem[i]));
      end
      exp_c++;
    end
    check({tag, "_wr_count"}, 64'(wr_addr_q.size()), 64'(n_wr));
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      check({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(i));
      check({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(src_mem[i]));
    end
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'(0));
    check({tag, "_busy_idle"}, 64'(busy), 64'(0));
    check({tag, "_out_count"}, 64'(out_count), 64'(n_wr));
    check({tag, "_err_timeout"}, 64'(err_timeout), 64'(exp_tmo));
    check({tag, "_err_extra"}, 64'(err_extra), 64'(exp_extra));
  endtask

  initial begin
    int s;
    int last_wr;

    // Reset state
    tick(3);
    check("reset_outputs", 64'(all_outs), 64'(0));
    rst_n = 1'b1;
    tick(2);

    // Nominal frame
    run_frame(1'b0, N, 1'b0, 0, s);
    verify("nominal", s, N, 1'b0, 1'b0);

    // Output bubbles
    run_frame(1'b1, N, 1'b0, 0, s);
    verify("bubbles", s, N, 1'b0, 1'b0);

    // Stalled filter: 8 outputs, watchdog expiry TMO idle cycles after the last write
    run_frame(1'b0, 8, 1'b0, 0, s);
    verify("stall", s, 8, 1'b1, 1'b0);
    last_wr = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] : 0;
    check("stall_done_delay", 64'(done_cyc - last_wr), 64'(TMO));

    // Extra output; the start also clears the sticky timeout left by the stall frame
    run_frame(1'b0, N, 1'b1, 0, s);
    verify("extra", s, N, 1'b0, 1'b1);

    // Start while busy is ignored
    run_frame(1'b0, N, 1'b0, 4, s);
    verify("restart_ignored", s, N, 1'b0, 1'b0);

    // Reset mid-FEED: outputs clear within the cycle, no completion afterwards
    bubbles = 1'b0; emit_limit = N; extra = 1'b0;
    for (int i = 0; i < N; i++) src_mem[i] = 8'($urandom);
    model_id++;
    mon_id++;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("busy_before_reset", 64'({busy, src_rd_en}), 64'(3));
    #1 rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", 64'(all_outs), 64'(0));
    tick(2);
    check("held_reset_outputs", 64'(all_outs), 64'(0));
    rst_n = 1'b1;
    mon_id++;
    tick(40);
    check("no_done_after_reset", 64'(done_cnt), 64'(0));
    check("no_write_after_reset", 64'(wr_addr_q.size()), 64'(0));
    check("no_read_after_reset", 64'(rd_addr_q.size()), 64'(0));
    check("idle_after_reset", 64'({busy, out_count}), 64'(0));

    // Clean frame after the reset
    run_frame(1'b0, N, 1'b0, 0, s);
    verify("post_reset", s, N, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed time %0t", $time);
    $fatal(1, "bench time limit");
  end

endmodule
